// File: rtl/csr_pkg.sv
// Shared CSR definitions: opcodes, addresses, trap causes, WARL masks and
// interrupt bit positions for the machine-mode CSR file.
package csr_pkg;

    typedef enum logic [1:0] {
        CSR_READ  = 2'd0,
        CSR_WRITE = 2'd1,
        CSR_SET   = 2'd2,
        CSR_CLEAR = 2'd3
    } csr_op_e;

    typedef enum logic [11:0] {
        CSR_MSTATUS       = 12'h300,
        CSR_MISA          = 12'h301,
        CSR_MIE           = 12'h304,
        CSR_MTVEC         = 12'h305,
        CSR_MCOUNTEREN    = 12'h306,
        CSR_MCOUNTINHIBIT = 12'h320,
        CSR_MSCRATCH      = 12'h340,
        CSR_MEPC          = 12'h341,
        CSR_MCAUSE        = 12'h342,
        CSR_MTVAL         = 12'h343,
        CSR_MIP           = 12'h344,
        CSR_MCYCLE        = 12'hB00,
        CSR_MINSTRET      = 12'hB02,
        CSR_MHARTID       = 12'hF14
    } csr_addrs_e;

    typedef enum logic [63:0] {
        CAUSE_INSN_MISALIGNED = 64'd0,
        CAUSE_INSN_FAULT      = 64'd1,
        CAUSE_ILLEGAL_INSN    = 64'd2,
        CAUSE_BREAKPOINT      = 64'd3,
        CAUSE_ECALL_M         = 64'd11,
        CAUSE_MSOFT_INT       = 64'h8000_0000_0000_0003,
        CAUSE_MTIMER_INT      = 64'h8000_0000_0000_0007,
        CAUSE_MEXT_INT        = 64'h8000_0000_0000_000B
    } csr_mcause_e;

    localparam logic [63:0] MstatusWmask       = 64'h0000_0000_0000_0088;
    localparam logic [63:0] MieWmask           = 64'h0000_0000_0000_0888;
    localparam logic [63:0] McountinhibitWmask = 64'h0000_0000_0000_0005;

    localparam int unsigned MsiBit         = 3;
    localparam int unsigned MtiBit         = 7;
    localparam int unsigned MeiBit         = 11;
    localparam int unsigned MstatusMieBit  = 3;
    localparam int unsigned MstatusMpieBit = 7;

    // Combine the old CSR value with the operand according to the CSR opcode.
    function automatic logic [63:0] csr_apply_op(csr_op_e op, logic [63:0] old_val,
                                                 logic [63:0] operand);
        logic [63:0] res;
        case (op)
            CSR_WRITE: res = operand;
            CSR_SET:   res = old_val | operand;
            CSR_CLEAR: res = old_val & ~operand;
            default:   res = old_val;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/csr_file_counter.sv
// 64-bit free-running counter with inhibit, increment enable and a write
// port that overrides the increment in the same cycle.
module csr_counter (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        inhibit_i,
    input  logic        inc_i,
    input  logic        we_i,
    input  logic [63:0] wdata_i,
    output logic [63:0] count_o
);

    logic [63:0] r_count;

    // Count register: reset, then write override, then gated increment (wraps naturally).
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_count <= '0;
        end else if (we_i) begin
            r_count <= wdata_i;
        end else if (inc_i && !inhibit_i) begin
            r_count <= r_count + 64'd1;
        end
    end

    assign count_o = r_count;

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file with trap entry/mret side effects, cycle and
// instret counters, and interrupt pending/cause generation.
module csr_file
    import csr_pkg::*;
#(
    parameter logic [63:0] HartId    = 64'd0,
    parameter logic [63:0] MisaValue = 64'h8000_0000_0000_0100
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        csr_valid_i,
    input  logic [1:0]  csr_op_i,
    input  logic [11:0] csr_addr_i,
    input  logic [63:0] csr_wdata_i,
    output logic [63:0] csr_rdata_o,
    output logic        csr_illegal_o,
    input  logic        trap_valid_i,
    input  logic [63:0] trap_cause_i,
    input  logic [63:0] trap_pc_i,
    input  logic [63:0] trap_tval_i,
    input  logic        mret_i,
    input  logic        instret_i,
    input  logic        irq_sw_i,
    input  logic        irq_timer_i,
    input  logic        irq_ext_i,
    output logic [63:0] trap_vector_o,
    output logic [63:0] mepc_o,
    output logic        irq_pending_o,
    output logic [63:0] irq_cause_o
);

    logic        r_mstatus_mie;
    logic        r_mstatus_mpie;
    logic [63:0] r_mie;
    logic [63:0] r_mtvec;
    logic [63:0] r_mscratch;
    logic [63:0] r_mepc;
    logic [63:0] r_mcause;
    logic [63:0] r_mtval;
    logic [63:0] r_mip;
    logic [63:0] r_mcountinhibit;

    logic [63:0] w_mcycle;
    logic [63:0] w_minstret;
    logic [63:0] w_mstatus;
    logic [63:0] w_old;
    logic [63:0] w_wval;
    logic [63:0] w_mip_next;
    logic [63:0] w_pend;
    logic [63:0] w_tvec_base;
    logic        w_known;
    logic        w_illegal;
    logic        w_we;
    csr_op_e     w_op;

    assign w_op = csr_op_e'(csr_op_i);

    // Assemble the architectural mstatus view; mpp is hardwired to machine mode.
    always_comb begin
        w_mstatus                 = '0;
        w_mstatus[12:11]          = 2'b11;
        w_mstatus[MstatusMieBit]  = r_mstatus_mie;
        w_mstatus[MstatusMpieBit] = r_mstatus_mpie;
    end

    // Address decode and old-value read mux; unknown addresses and mcounteren are illegal.
    always_comb begin
        w_known = 1'b1;
        w_old   = '0;
        case (csr_addr_i)
            CSR_MSTATUS:       w_old = w_mstatus;
            CSR_MISA:          w_old = MisaValue;
            CSR_MIE:           w_old = r_mie;
            CSR_MTVEC:         w_old = r_mtvec;
            CSR_MCOUNTINHIBIT: w_old = r_mcountinhibit;
            CSR_MSCRATCH:      w_old = r_mscratch;
            CSR_MEPC:          w_old = r_mepc;
            CSR_MCAUSE:        w_old = r_mcause;
            CSR_MTVAL:         w_old = r_mtval;
            CSR_MIP:           w_old = r_mip;
            CSR_MCYCLE:        w_old = w_mcycle;
            CSR_MINSTRET:      w_old = w_minstret;
            CSR_MHARTID:       w_old = HartId;
            default:           w_known = 1'b0;
        endcase
    end

    // Read-only space (addr[11:10]==11) rejects anything but a plain read.
    assign w_illegal     = !w_known || ((w_op != CSR_READ) && (csr_addr_i[11:10] == 2'b11));
    assign csr_illegal_o = csr_valid_i && w_illegal;
    assign csr_rdata_o   = (csr_valid_i && !w_illegal) ? w_old : '0;
    assign w_we          = csr_valid_i && !w_illegal && (w_op != CSR_READ);
    assign w_wval        = csr_apply_op(w_op, w_old, csr_wdata_i);

    // mstatus: trap entry beats mret, which beats a CSR write.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
        end else if (trap_valid_i) begin
            r_mstatus_mpie <= r_mstatus_mie;
            r_mstatus_mie  <= 1'b0;
        end else if (mret_i) begin
            r_mstatus_mie  <= r_mstatus_mpie;
            r_mstatus_mpie <= 1'b1;
        end else if (w_we && (csr_addr_i == CSR_MSTATUS)) begin
            r_mstatus_mie  <= (w_wval & MstatusWmask) != '0 && w_wval[MstatusMieBit];
            r_mstatus_mpie <= (w_wval & MstatusWmask) != '0 && w_wval[MstatusMpieBit];
        end
    end

    // Trap-state registers: trap entry overrides any coincident CSR write.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_mepc   <= '0;
            r_mcause <= '0;
            r_mtval  <= '0;
        end else if (trap_valid_i) begin
            r_mepc   <= {trap_pc_i[63:2], 2'b00};
            r_mcause <= trap_cause_i;
            r_mtval  <= trap_tval_i;
        end else if (w_we) begin
            if (csr_addr_i == CSR_MEPC)   r_mepc   <= {w_wval[63:2], 2'b00};
            if (csr_addr_i == CSR_MCAUSE) r_mcause <= w_wval;
            if (csr_addr_i == CSR_MTVAL)  r_mtval  <= w_wval;
        end
    end

    // Plain WARL CSRs, unaffected by trap or mret.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_mie           <= '0;
            r_mtvec         <= '0;
            r_mscratch      <= '0;
            r_mcountinhibit <= '0;
        end else if (w_we) begin
            if (csr_addr_i == CSR_MIE)           r_mie           <= w_wval & MieWmask;
            if (csr_addr_i == CSR_MTVEC)         r_mtvec         <= {w_wval[63:2], 1'b0, w_wval[0]};
            if (csr_addr_i == CSR_MSCRATCH)      r_mscratch      <= w_wval;
            if (csr_addr_i == CSR_MCOUNTINHIBIT) r_mcountinhibit <= w_wval & McountinhibitWmask;
        end
    end

    // Place the level interrupt sources at their mip bit positions.
    always_comb begin
        w_mip_next         = '0;
        w_mip_next[MsiBit] = irq_sw_i;
        w_mip_next[MtiBit] = irq_timer_i;
        w_mip_next[MeiBit] = irq_ext_i;
    end

    // mip is a one-cycle registered copy of the interrupt lines.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_mip <= '0;
        end else begin
            r_mip <= w_mip_next;
        end
    end

    csr_counter u_mcycle (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .inhibit_i (r_mcountinhibit[0]),
        .inc_i     (1'b1),
        .we_i      (w_we && (csr_addr_i == CSR_MCYCLE)),
        .wdata_i   (w_wval),
        .count_o   (w_mcycle)
    );

    csr_counter u_minstret (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .inhibit_i (r_mcountinhibit[2]),
        .inc_i     (instret_i),
        .we_i      (w_we && (csr_addr_i == CSR_MINSTRET)),
        .wdata_i   (w_wval),
        .count_o   (w_minstret)
    );

    // Vectored mode only applies to interrupt causes.
    assign w_tvec_base   = {r_mtvec[63:2], 2'b00};
    assign trap_vector_o = (r_mtvec[0] && trap_cause_i[63])
                         ? w_tvec_base + {56'd0, trap_cause_i[5:0], 2'b00}
                         : w_tvec_base;
    assign mepc_o        = r_mepc;

    assign w_pend        = r_mip & r_mie;
    assign irq_pending_o = r_mstatus_mie && (w_pend != '0);

    // Interrupt cause priority: external, then software, then timer.
    always_comb begin
        irq_cause_o = '0;
        if (w_pend[MeiBit]) begin
            irq_cause_o = CAUSE_MEXT_INT;
        end else if (w_pend[MsiBit]) begin
            irq_cause_o = CAUSE_MSOFT_INT;
        end else if (w_pend[MtiBit]) begin
            irq_cause_o = CAUSE_MTIMER_INT;
        end
    end

endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file: directed scenarios plus randomized
// traffic compared every cycle against a behavioural CSR model.
module tb_csr_file;

    logic        clk;
    logic        rst_ni;
    logic        csr_valid_i;
    logic [1:0]  csr_op_i;
    logic [11:0] csr_addr_i;
    logic [63:0] csr_wdata_i;
    logic [63:0] csr_rdata_o;
    logic        csr_illegal_o;
    logic        trap_valid_i;
    logic [63:0] trap_cause_i;
    logic [63:0] trap_pc_i;
    logic [63:0] trap_tval_i;
    logic        mret_i;
    logic        instret_i;
    logic        irq_sw_i;
    logic        irq_timer_i;
    logic        irq_ext_i;
    logic [63:0] trap_vector_o;
    logic [63:0] mepc_o;
    logic        irq_pending_o;
    logic [63:0] irq_cause_o;

    int n_chk = 0;
    int n_err = 0;
    bit started = 0;

    csr_file #(.HartId(64'd5), .MisaValue(64'h8000_0000_0000_0100)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .csr_valid_i   (csr_valid_i),
        .csr_op_i      (csr_op_i),
        .csr_addr_i    (csr_addr_i),
        .csr_wdata_i   (csr_wdata_i),
        .csr_rdata_o   (csr_rdata_o),
        .csr_illegal_o (csr_illegal_o),
        .trap_valid_i  (trap_valid_i),
        .trap_cause_i  (trap_cause_i),
        .trap_pc_i     (trap_pc_i),
        .trap_tval_i   (trap_tval_i),
        .mret_i        (mret_i),
        .instret_i     (instret_i),
        .irq_sw_i      (irq_sw_i),
        .irq_timer_i   (irq_timer_i),
        .irq_ext_i     (irq_ext_i),
        .trap_vector_o (trap_vector_o),
        .mepc_o        (mepc_o),
        .irq_pending_o (irq_pending_o),
        .irq_cause_o   (irq_cause_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit          m_st_mie, m_st_mpie;
    logic [63:0] m_mie, m_mtvec, m_scratch, m_mepc, m_mcause, m_mtval, m_mip, m_inh, m_cyc, m_ins;

    logic [11:0] legal_addrs [13] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h320, 12'h340,
                                      12'h341, 12'h342, 12'h343, 12'h344, 12'hB00, 12'hB02, 12'hF14};
    int irq_order [3] = '{11, 3, 7};

    function automatic bit m_legal(logic [11:0] a, logic [1:0] op);
        bit found = 0;
        foreach (legal_addrs[i]) if (legal_addrs[i] == a) found = 1;
        if (a == 12'hF14 && op != 2'd0) found = 0;
        return found;
    endfunction

    function automatic logic [63:0] m_read(logic [11:0] a);
        case (a)
            12'h300: return 64'h1800 | (64'(m_st_mie) << 3) | (64'(m_st_mpie) << 7);
            12'h301: return 64'h8000_0000_0000_0100;
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h320: return m_inh;
            12'h340: return m_scratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            12'h344: return m_mip;
            12'hB00: return m_cyc;
            12'hB02: return m_ins;
            12'hF14: return 64'd5;
            default: return 64'd0;
        endcase
    endfunction

    task automatic model_update();
        logic [63:0] old, wv, n_cyc, n_ins;
        bit legal, we, o_mie, o_mpie;
        if (!rst_ni) begin
            m_st_mie = 0; m_st_mpie = 0;
            m_mie = 0; m_mtvec = 0; m_scratch = 0; m_mepc = 0; m_mcause = 0;
            m_mtval = 0; m_mip = 0; m_inh = 0; m_cyc = 0; m_ins = 0;
            started = 1;
            return;
        end
        legal = m_legal(csr_addr_i, csr_op_i);
        we    = csr_valid_i && legal && (csr_op_i != 2'd0);
        old   = m_read(csr_addr_i);
        case (csr_op_i)
            2'd1:    wv = csr_wdata_i;
            2'd2:    wv = old | csr_wdata_i;
            default: wv = old & ~csr_wdata_i;
        endcase
        o_mie  = m_st_mie;
        o_mpie = m_st_mpie;
        n_cyc  = m_inh[0] ? m_cyc : m_cyc + 1;
        n_ins  = (m_inh[2] || !instret_i) ? m_ins : m_ins + 1;
        if (we) begin
            case (csr_addr_i)
                12'h300: if (!trap_valid_i && !mret_i) begin m_st_mie = wv[3]; m_st_mpie = wv[7]; end
                12'h304: m_mie = wv & 64'h888;
                12'h305: m_mtvec = wv & ~64'h2;
                12'h320: m_inh = wv & 64'h5;
                12'h340: m_scratch = wv;
                12'h341: if (!trap_valid_i) m_mepc = wv & ~64'h3;
                12'h342: if (!trap_valid_i) m_mcause = wv;
                12'h343: if (!trap_valid_i) m_mtval = wv;
                12'hB00: n_cyc = wv;
                12'hB02: n_ins = wv;
                default: ;
            endcase
        end
        if (trap_valid_i) begin
            m_st_mpie = o_mie; m_st_mie = 0;
            m_mepc = trap_pc_i & ~64'h3; m_mcause = trap_cause_i; m_mtval = trap_tval_i;
        end else if (mret_i) begin
            m_st_mie = o_mpie; m_st_mpie = 1;
        end
        m_cyc = n_cyc;
        m_ins = n_ins;
        m_mip = (64'(irq_ext_i) << 11) | (64'(irq_timer_i) << 7) | (64'(irq_sw_i) << 3);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        bit legal;
        logic [63:0] pend, cause, vec;
        if (!started) return;
        legal = m_legal(csr_addr_i, csr_op_i);
        chk("illegal", {63'd0, csr_illegal_o}, {63'd0, csr_valid_i && !legal});
        chk("rdata", csr_rdata_o, (csr_valid_i && legal) ? m_read(csr_addr_i) : 64'd0);
        vec = m_mtvec & ~64'h3;
        if (m_mtvec[0] && trap_cause_i[63]) vec = vec + 64'(trap_cause_i[5:0]) * 4;
        chk("trap_vector", trap_vector_o, vec);
        chk("mepc", mepc_o, m_mepc);
        pend  = m_mip & m_mie;
        cause = 0;
        for (int k = 2; k >= 0; k--)
            if (pend[irq_order[k]]) cause = 64'h8000_0000_0000_0000 | 64'(irq_order[k]);
        chk("irq_pending", {63'd0, irq_pending_o}, {63'd0, m_st_mie && (pend != 0)});
        chk("irq_cause", irq_cause_o, cause);
    endtask

    // Inputs are set at the falling edge; compare, then clock, then advance the model.
    task automatic cyc();
        #1 compare_all();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle();
        rst_ni = 1; csr_valid_i = 0; csr_op_i = 0; csr_addr_i = 0; csr_wdata_i = 0;
        trap_valid_i = 0; trap_cause_i = 0; trap_pc_i = 0; trap_tval_i = 0;
        mret_i = 0; instret_i = 0;
    endtask

    task automatic req(input logic [1:0] op, input logic [11:0] a, input logic [63:0] d);
        idle();
        csr_valid_i = 1; csr_op_i = op; csr_addr_i = a; csr_wdata_i = d;
    endtask

    logic [11:0] pool [16] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h320, 12'h340, 12'h341, 12'h342,
                               12'h343, 12'h344, 12'hB00, 12'hB02, 12'hF14, 12'h306, 12'h7C0, 12'h000};

    initial begin
        idle();
        irq_sw_i = 0; irq_timer_i = 0; irq_ext_i = 0;
        rst_ni = 0;
        cyc(); cyc();

        idle(); #1;
        chk("reset_rdata", csr_rdata_o, 64'd0);
        chk("reset_illegal", {63'd0, csr_illegal_o}, 64'd0);
        chk("reset_irq", {63'd0, irq_pending_o}, 64'd0);
        cyc();

        req(0, 12'hF14, 0); #1;
        chk("hartid_rd", csr_rdata_o, 64'd5);
        chk("hartid_legal", {63'd0, csr_illegal_o}, 64'd0);
        cyc();
        req(1, 12'hF14, 64'h123); #1;
        chk("hartid_wr_illegal", {63'd0, csr_illegal_o}, 64'd1);
        cyc();

        req(1, 12'h300, '1); cyc();
        req(0, 12'h300, 0); #1; chk("mstatus_all", csr_rdata_o, 64'h1888); cyc();
        req(3, 12'h300, 64'h8); cyc();
        req(0, 12'h300, 0); #1; chk("mstatus_clr", csr_rdata_o, 64'h1880); cyc();

        irq_ext_i = 1;
        req(1, 12'h305, 64'h8001); cyc();
        req(1, 12'h304, 64'h800); cyc();
        req(2, 12'h300, 64'h8); cyc();
        idle(); #1;
        chk("irq_pend_ext", {63'd0, irq_pending_o}, 64'd1);
        chk("irq_cause_ext", irq_cause_o, 64'h8000_0000_0000_000B);
        cyc();
        idle(); trap_valid_i = 1; trap_cause_i = 64'h8000_0000_0000_000B; trap_pc_i = 64'h2000; #1;
        chk("vec_ext", trap_vector_o, 64'h802C);
        cyc();
        req(0, 12'h300, 0); #1;
        chk("trap_mstatus", csr_rdata_o, 64'h1880);
        chk("trap_mepc", mepc_o, 64'h2000);
        chk("trap_irq_off", {63'd0, irq_pending_o}, 64'd0);
        cyc();
        idle(); mret_i = 1; cyc();
        irq_ext_i = 0;
        req(0, 12'h300, 0); #1; chk("mret_mstatus", csr_rdata_o, 64'h1888); cyc();

        req(1, 12'hB00, '1); cyc();
        req(0, 12'hB00, 0); #1; chk("mcycle_max", csr_rdata_o, 64'hFFFF_FFFF_FFFF_FFFF); cyc();
        req(0, 12'hB00, 0); #1; chk("mcycle_wrap", csr_rdata_o, 64'd0); cyc();
        req(2, 12'h320, 64'h1); cyc();
        idle(); cyc();
        req(0, 12'hB00, 0); #1; chk("mcycle_hold", csr_rdata_o, 64'd2); cyc();
        req(3, 12'h320, 64'h1); cyc();

        req(1, 12'h341, 64'h5550);
        trap_valid_i = 1; trap_cause_i = 64'd2; trap_pc_i = 64'h1004; trap_tval_i = 64'hDEAD;
        cyc();
        idle(); #1; chk("trap_beats_wr", mepc_o, 64'h1004); cyc();
        idle(); trap_valid_i = 1; mret_i = 1; trap_cause_i = 64'd3; trap_pc_i = 64'h3000; cyc();
        req(0, 12'h300, 0); #1;
        chk("trap_beats_mret", csr_rdata_o, 64'h1800);
        chk("trap_mret_mepc", mepc_o, 64'h3000);
        cyc();

        req(0, 12'h7C0, 0); #1;
        chk("bad_addr_illegal", {63'd0, csr_illegal_o}, 64'd1);
        chk("bad_addr_rdata", csr_rdata_o, 64'd0);
        cyc();
        req(0, 12'h306, 0); #1; chk("mcounteren_illegal", {63'd0, csr_illegal_o}, 64'd1); cyc();

        for (int n = 0; n < 3000; n++) begin
            idle();
            rst_ni       = ($urandom_range(0, 199) != 0);
            csr_valid_i  = $urandom_range(0, 3) != 0;
            csr_op_i     = 2'($urandom_range(0, 3));
            csr_addr_i   = pool[$urandom_range(0, 15)];
            if (csr_addr_i == 12'h000) csr_addr_i = 12'($urandom_range(0, 4095));
            csr_wdata_i  = ($urandom_range(0, 15) == 0) ? '1 : {$urandom, $urandom};
            trap_valid_i = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 3))
                0: trap_cause_i = 64'h8000_0000_0000_0003;
                1: trap_cause_i = 64'h8000_0000_0000_0007;
                2: trap_cause_i = 64'h8000_0000_0000_000B;
                default: trap_cause_i = {1'b0, 31'($urandom), $urandom};
            endcase
            trap_pc_i    = {$urandom, $urandom};
            trap_tval_i  = {$urandom, $urandom};
            mret_i       = ($urandom_range(0, 7) == 0);
            instret_i    = $urandom_range(0, 1) != 0;
            if ($urandom_range(0, 3) == 0) begin
                irq_sw_i    = $urandom_range(0, 1) != 0;
                irq_timer_i = $urandom_range(0, 1) != 0;
                irq_ext_i   = $urandom_range(0, 1) != 0;
            end
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/csr_file.md
Name: csr_file

Overview:
- Machine-mode CSR register file and trap-state unit for the RV64 core.
- Responds to CSR instruction requests from execute with read data and illegal flags.
- Applies trap-entry and mret side effects, runs mcycle/minstret, and signals pending interrupts to the pipeline.
- Consumes the CSR address, mcause and mstatus definitions from csr_pkg. The machine-only hart implements no S or U mode.

Parameters:
- HartId, 0: value returned by mhartid.
- MisaValue, 64'h8000_0000_0000_0100: misa read value (MXL=2, I); read-only.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; synchronous, active-low
- csr_valid_i  in  1  CSR request this cycle
- csr_op_i  in  2  0=Read, 1=Write, 2=Set, 3=Clear. Core maps rs1/uimm=0 Set/Clear to Read.
- csr_addr_i  in  12  CSR address
- csr_wdata_i  in  64  operand
- csr_rdata_o  out  64  old CSR value, combinational, same cycle
- csr_illegal_o  out  1  request illegal, combinational
- trap_valid_i  in  1  take trap this cycle
- trap_cause_i  in  64  mcause value, csr_mcause_e encoding
- trap_pc_i  in  64  faulting/interrupted PC
- trap_tval_i  in  64  mtval value
- mret_i  in  1  mret retiring
- instret_i  in  1  one instruction retired
- irq_sw_i, irq_timer_i, irq_ext_i  in  1 each  level interrupt sources
- trap_vector_o  out  64  redirect target for the current trap_cause_i
- mepc_o  out  64  mret target
- irq_pending_o  out  1  enabled interrupt pending and mstatus.mie=1
- irq_cause_o  out  64  highest-priority pending cause

Behaviour:
- Reset (rst_ni low at an edge): all state registers reset to 0, except mstatus.mpp, which is hardwired 2'b11. mip is 0. Outputs follow: rdata=0, illegal=0, irq_pending_o=0.
- Write data: Write uses wdata; Set uses old|wdata; Clear uses old&~wdata. The new value takes effect at the next edge, and the same-cycle read returns the old value.
- Illegal cases:
  - Address not in csr_addrs_e.
  - mcounteren, which is illegal because there is no U mode.
  - Op≠Read to mhartid (addr[11:10]==2'b11).
- An illegal request has no side effect and rdata=0. csr_illegal_o is gated by csr_valid_i.
- WARL masks:
  - mstatus: only mie(3) and mpie(7) are writable. mpp reads 11; all other bits read 0.
  - misa: writes ignored.
  - mie: bits 3, 7, 11 writable; others 0.
  - mip: read-only. It is a one-cycle registered copy of {ext,timer,sw} in bits 11, 7, 3.
  - mtvec: base[63:2] writable. mode[1] is forced 0, so mode ∈ {0,1}.
  - mepc: bits[1:0] forced 0.
  - mcause, mtval, mscratch: full 64 bits.
  - mcountinhibit: only CY(0) and IR(2) writable.
- Counters:
  - mcycle += 1 each cycle unless inhibit.CY.
  - minstret += instret_i unless inhibit.IR.
  - Both wrap 2^64−1 → 0.
  - A CSR write to a counter in the same cycle wins over the increment.
- Trap entry (trap_valid_i):
  - mepc←pc&~3, mcause←cause, mtval←tval.
  - mpie←mie, mie←0.
- trap_vector_o: if mtvec.mode=1 and cause[63]=1, it is base + 4·cause[5:0]; otherwise it is base. Combinational.
- mret_i: mie←mpie, mpie←1.
- Priority in the same cycle: trap > mret > CSR write.
  - A CSR write coincident with a trap or mret is dropped for the mstatus, mepc, mcause and mtval fields those events update.
  - Writes to other CSRs in that cycle still occur.
- Interrupts:
  - pend = mip & mie (registered mip).
  - Priority is MExt(11) > MSoft(3) > MTimer(7).
  - irq_pending_o = mstatus.mie & |pend.
  - irq_cause_o = {1, 63'd(code)}, or 0 if none.
- Reset asserted mid-operation overrides all events.

Decomposition:
- Add to csr_pkg:
  - csr_op_e.
  - WARL write masks (MstatusWmask, MieWmask, McountinhibitWmask).
  - Interrupt bit indices MsiBit=3, MtiBit=7, MeiBit=11.
- Sub-module csr_counter: 64-bit counter with inhibit, increment enable and write-override. Instantiated twice, for mcycle and minstret.

Test Plan:
- Reset, then Read mhartid (HartId=5) → rdata=5, illegal=0. Write to mhartid → illegal=1 and no state change.
- Write mstatus=~0 → mstatus reads 0x1888 (mie, mpie, mpp=11). Clear 0x8 → mstatus reads 0x1880.
- mtvec=0x8001, mie=0x800, mstatus.mie=1, irq_ext_i=1: one cycle later irq_pending_o=1 and irq_cause_o=MExtInt. A trap with that cause gives trap_vector_o=0x802C, mepc=pc, mie=0, mpie=1. mret next cycle → mie=1.
- mcycle written to 2^64−1 → wraps to 0 on the following cycle. Set mcountinhibit=1 → mcycle holds.
- Trap and CSR Write to mepc in the same cycle → mepc = trap pc (0x1004), not wdata. Simultaneous mret and trap → trap effects only.
- Read 0x7C0 → illegal=1, rdata=0. Read mcounteren → illegal=1.
